// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// operation encoding, FSM state codes and operation-class helpers.
package muldiv_pkg;

   // funct3 encoding of the M-extension operations
   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } op_e;

   // FSM state codes
   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_CALC = 2'b01;
   localparam logic [1:0] ST_FIX  = 2'b10;
   localparam logic [1:0] ST_DONE = 2'b11;

   // True for DIV/DIVU/REM/REMU
   function automatic logic is_div(input op_e op);
      logic r;
      case (op)
         OP_DIV, OP_DIVU, OP_REM, OP_REMU: r = 1'b1;
         default:                          r = 1'b0;
      endcase
      return r;
   endfunction

   // True for REM/REMU (remainder is the selected result)
   function automatic logic is_rem(input op_e op);
      logic r;
      case (op)
         OP_REM, OP_REMU: r = 1'b1;
         default:         r = 1'b0;
      endcase
      return r;
   endfunction

   // rs1 is interpreted as signed
   function automatic logic is_signed_a(input op_e op);
      logic r;
      case (op)
         OP_MULH, OP_MULHSU, OP_DIV, OP_REM: r = 1'b1;
         default:                            r = 1'b0;
      endcase
      return r;
   endfunction

   // rs2 is interpreted as signed
   function automatic logic is_signed_b(input op_e op);
      logic r;
      case (op)
         OP_MULH, OP_DIV, OP_REM: r = 1'b1;
         default:                 r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the Execute stage.
// Works on operand magnitudes: shift-add multiply or restoring divide,
// one bit per cycle, in a single 2*XLEN accumulator; signs are applied
// in the FIX state. Divide-by-zero and signed overflow finish from IDLE.
module ex_muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flushE,
   input  logic            MulDivE,
   input  logic [2:0]      funct3E,
   input  logic [XLEN-1:0] SrcAE,
   input  logic [XLEN-1:0] SrcBE,
   output logic            busyE,
   output logic            doneE,
   output logic [XLEN-1:0] MulDivResultE
);

   localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
   localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
   localparam logic [XLEN-1:0] ZERO_X   = {XLEN{1'b0}};

   logic [1:0]        state_q, state_d;
   op_e               op_q, op_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   opb_q, opb_d;
   logic              sign_a_q, sign_a_d;
   logic              sign_b_q, sign_b_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [XLEN-1:0]   result_q, result_d;

   // operand decode for the start cycle
   op_e               op_in_s;
   logic              sign_a_in_s, sign_b_in_s;
   logic [XLEN-1:0]   mag_a_s, mag_b_s;
   logic              div_zero_s, div_ovf_s;

   assign op_in_s     = op_e'(funct3E);
   assign sign_a_in_s = is_signed_a(op_in_s) & SrcAE[XLEN-1];
   assign sign_b_in_s = is_signed_b(op_in_s) & SrcBE[XLEN-1];
   assign mag_a_s     = sign_a_in_s ? (ZERO_X - SrcAE) : SrcAE;
   assign mag_b_s     = sign_b_in_s ? (ZERO_X - SrcBE) : SrcBE;
   assign div_zero_s  = (SrcBE == ZERO_X);
   assign div_ovf_s   = is_signed_a(op_in_s) & (SrcAE == MIN_NEG) & (SrcBE == ALL_ONES);

   // one multiply step: add multiplicand to upper half when LSB set, shift right
   logic [XLEN:0]     mul_sum_s;
   logic [2*XLEN-1:0] mul_next_s;
   assign mul_sum_s  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
   assign mul_next_s = {mul_sum_s, acc_q[XLEN-1:1]};

   // one restoring divide step on {rem, quot}: shift left, trial-subtract divisor
   logic [XLEN:0]     div_trial_s;
   logic [2*XLEN-1:0] div_next_s;
   assign div_trial_s = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opb_q};
   assign div_next_s  = div_trial_s[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                          : {div_trial_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

   // sign fix-up of the finished magnitudes
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   quot_s, rem_s;
   assign prod_s = (sign_a_q ^ sign_b_q) ? ({(2*XLEN){1'b0}} - acc_q) : acc_q;
   assign quot_s = (sign_a_q ^ sign_b_q) ? (ZERO_X - acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
   assign rem_s  = sign_a_q ? (ZERO_X - acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];

   // next-state logic for the FSM and datapath; flush kills any op
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      acc_d    = acc_q;
      opb_d    = opb_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      case (state_q)
         ST_IDLE: begin
            if (MulDivE) begin
               op_d     = op_in_s;
               sign_a_d = sign_a_in_s;
               sign_b_d = sign_b_in_s;
               if (is_div(op_in_s) && div_zero_s) begin
                  result_d = is_rem(op_in_s) ? SrcAE : ALL_ONES;
                  cnt_d    = {CW{1'b0}};
                  state_d  = ST_DONE;
               end else if (is_div(op_in_s) && div_ovf_s) begin
                  result_d = is_rem(op_in_s) ? ZERO_X : SrcAE;
                  cnt_d    = {CW{1'b0}};
                  state_d  = ST_DONE;
               end else begin
                  acc_d   = {ZERO_X, mag_a_s};
                  opb_d   = mag_b_s;
                  cnt_d   = CW'(XLEN - 1);
                  state_d = ST_CALC;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CALC: begin
            acc_d = is_div(op_q) ? div_next_s : mul_next_s;
            if (cnt_q == {CW{1'b0}}) begin
               state_d = ST_FIX;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_FIX: begin
            case (op_q)
               OP_MUL:                        result_d = prod_s[XLEN-1:0];
               OP_MULH, OP_MULHSU, OP_MULHU:  result_d = prod_s[2*XLEN-1:XLEN];
               OP_DIV, OP_DIVU:               result_d = quot_s;
               OP_REM, OP_REMU:               result_d = rem_s;
               default:                       result_d = ZERO_X;
            endcase
            state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = {CW{1'b0}};
         end
      endcase
      if (flushE) begin
         state_d  = ST_IDLE;
         cnt_d    = {CW{1'b0}};
         result_d = ZERO_X;
      end else begin
         state_d = state_d;
      end
   end

   // state registers; reset has priority over everything
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         op_q     <= OP_MUL;
         acc_q    <= {(2*XLEN){1'b0}};
         opb_q    <= ZERO_X;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         cnt_q    <= {CW{1'b0}};
         result_q <= ZERO_X;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         acc_q    <= acc_d;
         opb_q    <= opb_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   assign doneE         = (state_q == ST_DONE);
   assign busyE         = MulDivE & ~doneE;
   assign MulDivResultE = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: the driver pushes expected result
// and completion cycle per op; a negedge monitor pops on every doneE.
module tb_ex_muldiv_unit;

   logic        clk;
   logic        reset;
   logic        flushE;
   logic        MulDivE;
   logic [2:0]  funct3E;
   logic [31:0] SrcAE;
   logic [31:0] SrcBE;
   logic        busyE;
   logic        doneE;
   logic [31:0] MulDivResultE;

   typedef struct {
      logic [31:0] exp;
      int          due;
      int          id;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   op_id  = 0;

   ex_muldiv_unit #(.XLEN(32)) dut (
      .clk(clk), .reset(reset), .flushE(flushE), .MulDivE(MulDivE),
      .funct3E(funct3E), .SrcAE(SrcAE), .SrcBE(SrcBE),
      .busyE(busyE), .doneE(doneE), .MulDivResultE(MulDivResultE)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // cycle counter: cycle N is the interval after the Nth rising edge
   always @(posedge clk) cyc <= cyc + 1;

   // monitor: every doneE pulse must match the oldest expectation
   always @(negedge clk) begin
      if (doneE) begin
         checks = checks + 1;
         if (exp_q.size() == 0) begin
            errors = errors + 1;
            $display("FAIL unexpected_done cycle %0d result %h required no doneE", cyc, MulDivResultE);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (MulDivResultE !== e.exp || cyc != e.due || busyE !== 1'b0) begin
               errors = errors + 1;
               $display("FAIL op%0d result %h cycle %0d busy %b required %h cycle %0d busy 0",
                        e.id, MulDivResultE, cyc, busyE, e.exp, e.due);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks = checks + 1;
      if (act !== req) begin
         errors = errors + 1;
         $display("FAIL %s actual %h required %h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // issue one M op with MulDivE held until doneE, like a stalled pipeline
   task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat);
      bit seen;
      exp_t e;
      MulDivE = 1'b1;
      funct3E = f3;
      SrcAE   = a;
      SrcBE   = b;
      e.exp = exp;
      e.due = cyc + lat;
      e.id  = op_id;
      exp_q.push_back(e);
      op_id = op_id + 1;
      seen  = 1'b0;
      for (int k = 0; k < 100 && !seen; k++) begin
         @(negedge clk);
         if (doneE) begin
            seen = 1'b1;
         end else begin
            chk("busy_while_pending", {31'd0, busyE}, 32'd1);
         end
         tick();
         if (k == 2 && lat > 1) begin
            SrcAE   = 32'hDEADBEEF;
            SrcBE   = 32'h00000003;
            funct3E = ~f3;
         end
      end
      if (!seen) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("FAIL timeout op%0d no doneE within 100 cycles", e.id);
         if (exp_q.size() != 0) void'(exp_q.pop_back());
      end
   endtask

   task automatic idle(input int n);
      MulDivE = 1'b0;
      repeat (n) tick();
   endtask

   initial begin
      reset = 1'b1; flushE = 1'b0; MulDivE = 1'b0;
      funct3E = 3'd0; SrcAE = 32'd0; SrcBE = 32'd0;
      repeat (3) tick();
      @(negedge clk);
      chk("reset_done", {31'd0, doneE}, 32'd0);
      chk("reset_busy", {31'd0, busyE}, 32'd0);
      chk("reset_result", MulDivResultE, 32'd0);
      tick();
      reset = 1'b0;
      idle(2);

      // multiplies
      do_op(3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34);
      idle(1);
      do_op(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34);
      idle(1);
      do_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
      idle(1);
      do_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
      idle(1);
      do_op(3'b000, 32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001, 34);
      idle(1);

      // divides
      do_op(3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34);
      idle(1);
      do_op(3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34);
      idle(1);
      do_op(3'b101, 32'd100,      32'd7,        32'd14,       34);
      idle(1);
      do_op(3'b111, 32'd100,      32'd7,        32'd2,        34);
      idle(1);
      do_op(3'b100, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 34);
      idle(1);
      do_op(3'b110, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 34);
      idle(1);
      do_op(3'b100, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 34);
      idle(1);
      do_op(3'b110, 32'd100,      32'hFFFFFFF9, 32'd2,        34);
      idle(1);
      do_op(3'b101, 32'h80000000, 32'hFFFFFFFF, 32'd0,        34);
      idle(1);

      // special divides finish one cycle after issue
      do_op(3'b100, 32'h00001234, 32'd0,        32'hFFFFFFFF, 1);
      idle(1);
      do_op(3'b110, 32'd5,        32'd0,        32'd5,        1);
      idle(1);
      do_op(3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
      do_op(3'b111, 32'd5,        32'd0,        32'd5,        1);
      idle(1);
      do_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
      idle(1);
      do_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);
      idle(3);
      chk("result_holds", MulDivResultE, 32'd0);

      // back-to-back DIVU then MUL, MulDivE never dropped
      do_op(3'b101, 32'd1000,     32'd10,       32'd100,      34);
      do_op(3'b000, 32'd6,        32'd7,        32'd42,       34);
      idle(2);
      chk("result_holds_b2b", MulDivResultE, 32'd42);

      // flush in CALC cycle 10 kills the op
      MulDivE = 1'b1; funct3E = 3'b101; SrcAE = 32'd100; SrcBE = 32'd7;
      repeat (10) tick();
      flushE = 1'b1;
      tick();
      flushE = 1'b0; MulDivE = 1'b0;
      @(negedge clk);
      chk("flush_done", {31'd0, doneE}, 32'd0);
      chk("flush_result_cleared", MulDivResultE, 32'd0);
      tick();
      idle(40);
      do_op(3'b000, 32'd9,        32'd9,        32'd81,       34);

      // flush beats MulDivE in IDLE
      flushE = 1'b1; MulDivE = 1'b1; funct3E = 3'b100; SrcAE = 32'd8; SrcBE = 32'd0;
      tick();
      flushE = 1'b0;
      idle(4);
      do_op(3'b110, 32'd17,       32'd5,        32'd2,        34);
      idle(1);

      // reset mid-CALC
      MulDivE = 1'b1; funct3E = 3'b000; SrcAE = 32'd3; SrcBE = 32'd4;
      repeat (10) tick();
      reset = 1'b1; MulDivE = 1'b0;
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_calc_done", {31'd0, doneE}, 32'd0);
      chk("rst_calc_busy", {31'd0, busyE}, 32'd0);
      chk("rst_calc_result", MulDivResultE, 32'd0);
      tick();
      idle(40);
      do_op(3'b011, 32'h00010000, 32'h00010000, 32'd1,        34);
      idle(5);

      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
